// File: rtl/non_restoring_div_pkg.sv
// Shared definitions for the non-restoring divider: FSM encoding and legal WIDTH range.
package non_restoring_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StIter = ST_ITER,
        StFix  = ST_FIX,
        StDone = ST_DONE
    } nrd_state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic bit width_ok(int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/nrd_addsub_step.sv
// One non-restoring iteration: shift {A,Q} left, then add or subtract M by A's sign.
module nrd_addsub_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   a,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next
);

    logic [WIDTH:0] shifted;

    assign shifted = {a[WIDTH-1:0], q_msb};
    // Intermediate may wrap mod 2^(WIDTH+1); the result always lands back in [-M, M).
    assign a_next  = a[WIDTH] ? (shifted + {1'b0, m}) : (shifted - {1'b0, m});

endmodule

// File: rtl/non_restoring_divider_n.sv
// Multi-cycle non-restoring divider, signed or unsigned, with div-by-zero and overflow flags.
module non_restoring_divider_n
    import non_restoring_div_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("non_restoring_divider_n: WIDTH out of range");
    end

    nrd_state_e     state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CW-1:0]    count_q, count_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             signed_eff;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   a_step, a_fix;
    logic [WIDTH-1:0] rem_mag;

    assign signed_eff = SIGNED_EN && signed_mode;
    assign dvd_neg    = signed_eff && dividend[WIDTH-1];
    assign dvs_neg    = signed_eff && divisor[WIDTH-1];
    // |MIN| wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign dvd_mag    = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
    assign dvs_mag    = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;

    nrd_addsub_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_q),
        .q_msb  (q_q[WIDTH-1]),
        .m      (m_q),
        .a_next (a_step)
    );

    assign a_fix   = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;
    assign rem_mag = a_fix[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        count_d     = count_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        ovf_pend_d  = ovf_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        state_d     = StDone;
                    end else begin
                        a_d        = '0;
                        q_d        = dvd_mag;
                        m_d        = dvs_mag;
                        count_d    = '0;
                        neg_quo_d  = dvd_neg ^ dvs_neg;
                        neg_rem_d  = dvd_neg;
                        ovf_pend_d = signed_eff
                                     && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                                     && (divisor == '1);
                        state_d    = StIter;
                    end
                end
            end
            StIter: begin
                a_d     = a_step;
                q_d     = {q_q[WIDTH-2:0], ~a_step[WIDTH]};
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                a_d         = a_fix;
                quotient_d  = neg_quo_q ? (~q_q + WIDTH'(1)) : q_q;
                remainder_d = neg_rem_q ? (~rem_mag + WIDTH'(1)) : rem_mag;
                dbz_d       = 1'b0;
                ovf_d       = ovf_pend_q;
                state_d     = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            count_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            count_q     <= count_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            ovf_pend_q  <= ovf_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy        = (state_q == StIter) || (state_q == StFix);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_non_restoring_divider_n.sv
// Scoreboard bench for non_restoring_divider_n (WIDTH=8): directed vectors, decoupled monitor.
module tb_non_restoring_divider_n;

    localparam int unsigned W = 8;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         edges;
        int         busy_cycles;
        int         issue;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    exp_t sb[$];

    non_restoring_divider_n #(
        .WIDTH     (W),
        .SIGNED_EN (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller aligns to a negedge first; start is held for exactly the next rising edge.
    task automatic issue(input string name, input logic sm, input logic [7:0] dvd,
                         input logic [7:0] dvs, input logic [7:0] eq, input logic [7:0] er,
                         input logic edbz, input logic eovf, input bit push);
        exp_t e;
        start       = 1'b1;
        signed_mode = sm;
        dividend    = dvd;
        divisor     = dvs;
        if (push) begin
            e.name        = name;
            e.q           = eq;
            e.r           = er;
            e.dbz         = edbz;
            e.ovf         = eovf;
            e.edges       = edbz ? 0 : W + 1;
            e.busy_cycles = edbz ? 0 : W + 1;
            e.issue       = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check({name, "_drain"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_op(input string name, input logic sm, input logic [7:0] dvd,
                          input logic [7:0] dvs, input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input logic eovf);
        @(negedge clk);
        issue(name, sm, dvd, dvs, eq, er, edbz, eovf, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_empty(name);
    endtask

    // Monitor: pops one expectation per done pulse and checks result, latency and busy length.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none",
                                 cyc);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_quotient"}, quotient, e.q);
                        check({e.name, "_remainder"}, remainder, e.r);
                        check({e.name, "_div_by_zero"}, div_by_zero, e.dbz);
                        check({e.name, "_overflow"}, overflow, e.ovf);
                        check({e.name, "_latency"}, cyc - e.issue - 1, e.edges);
                        check({e.name, "_busy_len"}, busy_cnt, e.busy_cycles);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        check("reset_ovf", overflow, 0);
        rst = 1'b1;

        run_op("u100_7",   1'b0, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 1'b0);
        run_op("s-100_7",  1'b1, 8'h9C,  8'd7,   8'hF2,  8'hFE, 1'b0, 1'b0);
        run_op("u156_7",   1'b0, 8'h9C,  8'd7,   8'd22,  8'd2,  1'b0, 1'b0);
        run_op("s7_-2",    1'b1, 8'd7,   8'hFE,  8'hFD,  8'd1,  1'b0, 1'b0);
        run_op("s-7_2",    1'b1, 8'hF9,  8'd2,   8'hFD,  8'hFF, 1'b0, 1'b0);
        run_op("u55_0",    1'b0, 8'd55,  8'd0,   8'hFF,  8'd55, 1'b1, 1'b0);
        run_op("s-128_-1", 1'b1, 8'h80,  8'hFF,  8'h80,  8'h00, 1'b0, 1'b1);
        run_op("u255_1",   1'b0, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 1'b0);
        run_op("u255_255", 1'b0, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 1'b0);

        // Restart in the DONE cycle, then a start pulse during ITER that must be ignored.
        @(negedge clk);
        issue("u17_5", 1'b0, 8'd17, 8'd5, 8'd3, 8'd2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("restart_done_seen", seen, 1);
        issue("u200_3", 1'b0, 8'd200, 8'd3, 8'd66, 8'd2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        issue("ignored", 1'b0, 8'd50, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_empty("restart");

        // Reset during ITER with count==4: outputs clear at once, no done afterwards.
        @(negedge clk);
        issue("aborted", 1'b0, 8'd100, 8'd7, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        check("abort_ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue("u9_2", 1'b0, 8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_empty("post_reset");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/non_restoring_divider_n.md
NON_RESTORING_DIVIDER_N -- requirements
Module: non_restoring_divider_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width (legal range 2..32).
REQ-002 The block SHALL have parameter SIGNED_EN, default 1; when 0, signed_mode is ignored and treated as 0.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 dividend  input  WIDTH  numerator; sampled with start.
REQ-008 divisor  input  WIDTH  denominator; sampled with start.
REQ-009 busy  output  1  high in ITER and FIX.
REQ-010 done  output  1  one-cycle pulse; results valid.
REQ-011 quotient  output  WIDTH  registered result, held until next done.
REQ-012 remainder  output  WIDTH  registered result, held until next done.
REQ-013 div_by_zero  output  1  registered flag, updated with done.
REQ-014 overflow  output  1  registered flag: signed MIN / -1, updated with done.

Function
REQ-015 The FSM SHALL have states IDLE, ITER, FIX and DONE.
REQ-016 IDLE/DONE with start=1 and divisor!=0: load A=0 (WIDTH+1 bits), Q=|dividend|, M=|divisor|, count=0, latch sign flags; go to ITER.
REQ-017 IDLE/DONE with start=1 and divisor==0: go to DONE next edge; quotient=all ones, remainder=dividend, div_by_zero=1, overflow=0.
REQ-018 Each ITER edge: shift {A,Q} left 1; A = A-M if old A[WIDTH]=0, else A+M; Q[0] = ~new A[WIDTH]; count++.
REQ-019 ITER SHALL last exactly WIDTH edges; when count==WIDTH-1, go to FIX.
REQ-020 On the FIX edge: if A[WIDTH]=1, add M to A. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign. Load the output registers and flags, then go to DONE.
REQ-021 Signed results SHALL truncate toward zero; |remainder| < |divisor|.
REQ-022 Signed dividend=MIN, divisor=-1 SHALL yield quotient=MIN, remainder=0, overflow=1.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE unless start=1.
REQ-024 Latency SHALL be: done high in the cycle after edge WIDTH+1, counted from the start-sampling edge (edge 0).
REQ-025 start while busy=1 SHALL be ignored; operands are not resampled.
REQ-026 Magnitude arithmetic SHALL be unsigned WIDTH bits; |MIN| = 2^(WIDTH-1) with no saturation.
REQ-027 The counter SHALL be clog2(WIDTH+1) bits and SHALL not wrap during ITER.

Reset
REQ-028 rst low SHALL immediately force state=IDLE and clear A, Q, M, count, busy, done, quotient, remainder, div_by_zero and overflow to 0.
REQ-029 Reset mid-operation SHALL abandon the division; no done pulse SHALL follow the release of reset.
REQ-030 After rst rises, the first start SHALL be accepted on the first rising edge.

Structure
REQ-031 Package non_restoring_div_pkg SHALL hold the FSM state encoding (2-bit localparams) and a WIDTH-range check constant.
REQ-032 One sub-module, nrd_addsub_step (WIDTH+1-bit add/subtract selected by the sign bit), SHALL implement the REQ-018 datapath step.
REQ-033 The datapath and FSM SHALL remain in the top module; no latches; every register SHALL be on the async reset.

Verification (WIDTH=8)
REQ-034 Unsigned 100/7 -> quotient=14, remainder=2, done on the 9th edge after the start edge, busy high for 9 cycles.
REQ-035 Signed -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2), overflow=0.
REQ-036 55/0 -> done one cycle after start, quotient=0xFF, remainder=55, div_by_zero=1.
REQ-037 Signed -128/-1 -> quotient=0x80, remainder=0, overflow=1; unsigned 255/1 -> quotient=255, remainder=0.
REQ-038 start in the DONE cycle with 200/3 -> immediate restart, quotient=66, remainder=2; start pulsed during ITER is ignored.
REQ-039 rst low during ITER count=4 -> all outputs 0 at once, no done pulse; next start 9/2 -> quotient=4, remainder=1.
